// File: rtl/cpu_datapath.sv
// ============================================================================
// Module   : cpu_datapath
// Brief    : 8-bit, 4-register single-cycle CPU datapath with an internal
//            clock divider and a two-digit 7-segment display of the last datum.
//            Optional macro DISPLAY_PC_EN shows the PC on the display instead.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_datapath #(
  parameter int CLK_DIV   = 2,
  parameter int MEM_DEPTH = 32
) (
  input  logic       _CLK,
  input  logic       RESET,
  input  logic [7:0] instruction,
  output logic [7:0] PC,
  output logic [6:0] m,
  output logic [6:0] l,
  output logic       CLK_
);

  localparam int c_CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int c_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLK_DIV - 1);

  localparam logic [1:0] c_OP_ADD = 2'b00;
  localparam logic [1:0] c_OP_LW  = 2'b01;
  localparam logic [1:0] c_OP_SW  = 2'b10;
  localparam logic [1:0] c_OP_JMP = 2'b11;

  logic [c_CNT_W-1:0] r_div_cnt;
  logic               r_clk_div;
  logic [7:0]         r_pc;
  logic [7:0]         r_disp;
  logic [7:0]         r_regs [4];
  logic [7:0]         r_mem  [MEM_DEPTH];

  logic               w_div_wrap;
  logic               w_commit;
  logic [1:0]         w_op;
  logic [1:0]         w_rs;
  logic [1:0]         w_rt;
  logic [1:0]         w_rd;
  logic [7:0]         w_imm2_sext;
  logic [7:0]         w_imm6_sext;
  logic [7:0]         w_rs_val;
  logic [7:0]         w_rt_val;
  logic [7:0]         w_sum;
  logic [7:0]         w_addr;
  logic [c_AW-1:0]    w_mem_idx;
  logic [7:0]         w_load;
  logic [7:0]         w_show;

  // Architectural state only changes on the _CLK edge where CLK_ falls.
  assign w_div_wrap = (r_div_cnt == c_CNT_MAX);
  assign w_commit   = w_div_wrap & r_clk_div;

  assign w_op        = instruction[7:6];
  assign w_rs        = instruction[5:4];
  assign w_rt        = instruction[3:2];
  assign w_rd        = instruction[1:0];
  assign w_imm2_sext = {{6{instruction[1]}}, instruction[1:0]};
  assign w_imm6_sext = {{2{instruction[5]}}, instruction[5:0]};

  assign w_rs_val  = r_regs[w_rs];
  assign w_rt_val  = r_regs[w_rt];
  assign w_sum     = w_rs_val + w_rt_val;
  assign w_addr    = w_rs_val + w_imm2_sext;
  assign w_mem_idx = w_addr[c_AW-1:0];
  assign w_load    = r_mem[w_mem_idx];

  always_ff @(posedge _CLK) begin
    if (RESET) begin
      r_div_cnt <= '0;
      r_clk_div <= 1'b0;
      r_pc      <= 8'd0;
      r_disp    <= 8'd0;
      for (int i = 0; i < 4; i++) begin
        r_regs[i] <= 8'd0;
      end
      for (int i = 0; i < MEM_DEPTH; i++) begin
        r_mem[i] <= 8'(i);
      end
    end else begin
      if (w_div_wrap) begin
        r_div_cnt <= '0;
        r_clk_div <= ~r_clk_div;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end

      if (w_commit) begin
        case (w_op)
          c_OP_ADD: begin
            r_regs[w_rd] <= w_sum;
            r_disp       <= w_sum;
            r_pc         <= r_pc + 8'd1;
          end
          c_OP_LW: begin
            r_regs[w_rt] <= w_load;
            r_disp       <= w_load;
            r_pc         <= r_pc + 8'd1;
          end
          c_OP_SW: begin
            r_mem[w_mem_idx] <= w_rt_val;
            r_disp           <= w_rt_val;
            r_pc             <= r_pc + 8'd1;
          end
          c_OP_JMP: begin
            r_pc <= r_pc + 8'd1 + w_imm6_sext;
          end
          default: begin
            r_pc <= r_pc + 8'd1;
          end
        endcase
      end
    end
  end

  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] f_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

`ifdef DISPLAY_PC_EN
  assign w_show = r_pc;
`else
  assign w_show = r_disp;
`endif

  assign m    = f_seg(w_show[7:4]);
  assign l    = f_seg(w_show[3:0]);
  assign PC   = r_pc;
  assign CLK_ = r_clk_div;

endmodule

`default_nettype wire

// File: tb/tb_cpu_datapath.sv
// ============================================================================
// Module   : tb_cpu_datapath
// Brief    : Scoreboard bench for cpu_datapath: directed instructions push the
//            expected PC/display, a monitor compares on every commit edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_datapath;

  localparam int c_CLK_DIV = 2;

  logic       _CLK;
  logic       RESET;
  logic [7:0] instruction;
  logic [7:0] PC;
  logic [6:0] m;
  logic [6:0] l;
  logic       CLK_;

  cpu_datapath #(
    .CLK_DIV  (c_CLK_DIV),
    .MEM_DEPTH(32)
  ) u_dut (
    ._CLK       (_CLK),
    .RESET      (RESET),
    .instruction(instruction),
    .PC         (PC),
    .m          (m),
    .l          (l),
    .CLK_       (CLK_)
  );

  initial _CLK = 1'b0;
  always #5 _CLK = ~_CLK;

  typedef struct {
    string      name;
    logic [7:0] pc;
    logic [7:0] disp;
  } exp_t;

  typedef struct {
    logic [7:0] ins;
    logic [7:0] pc;
    logic [7:0] disp;
  } vec_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_en   = 1'b0;

  // Directed program: instruction, PC after commit, display after commit.
  vec_t vecs[22] = '{
    '{8'b01110001, 8'd1,   8'h01},
    '{8'b01001101, 8'd2,   8'h02},
    '{8'b01110100, 8'd3,   8'h02},
    '{8'b10110111, 8'd4,   8'h02},
    '{8'b00000101, 8'd5,   8'h03},
    '{8'b11111010, 8'd0,   8'h03},
    '{8'b01101001, 8'd1,   8'h02},
    '{8'b01001111, 8'd2,   8'h00},
    '{8'b01110011, 8'd3,   8'h1F},
    '{8'b00010101, 8'd4,   8'h06},
    '{8'b00010101, 8'd5,   8'h0C},
    '{8'b00010101, 8'd6,   8'h18},
    '{8'b01010101, 8'd7,   8'h19},
    '{8'b00010101, 8'd8,   8'h32},
    '{8'b00010101, 8'd9,   8'h64},
    '{8'b00010110, 8'd10,  8'hC8},
    '{8'b00100111, 8'd11,  8'h2C},
    '{8'b11110100, 8'd0,   8'h2C},
    '{8'b11111110, 8'd255, 8'h2C},
    '{8'b11000000, 8'd0,   8'h2C},
    '{8'b11111110, 8'd255, 8'h2C},
    '{8'b00000000, 8'd0,   8'h3E}
  };

  function automatic logic [6:0] seg_ref(input logic [3:0] d);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[d];
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic wait_level(input logic v, input string what);
    int n = 0;
    while (CLK_ !== v && n < 64) begin
      @(posedge _CLK);
      #1;
      n++;
    end
    if (CLK_ !== v) begin
      n_checks++;
      $display("FAIL timeout_%s: CLK_ got %b expected %b", what, CLK_, v);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"},   {24'd0, PC},   32'd0);
    check({tag, "_clk"},  {31'd0, CLK_}, 32'd0);
    check({tag, "_m"},    {25'd0, m},    {25'd0, 7'b1000000});
    check({tag, "_l"},    {25'd0, l},    {25'd0, 7'b1000000});
  endtask

  task automatic check_rise_latency(input string tag);
    int n = 0;
    do begin
      @(posedge _CLK);
      #1;
      n++;
    end while (CLK_ !== 1'b1 && n < 64);
    check({tag, "_rise_latency"}, n, c_CLK_DIV);
  endtask

  task automatic issue(input logic [7:0] ins, input string name,
                       input logic [7:0] pc, input logic [7:0] disp);
    exp_t e;
    e.name = name;
    e.pc   = pc;
    e.disp = disp;
    instruction = ins;
    sb_q.push_back(e);
    wait_level(1'b0, {name, "_fall"});
    wait_level(1'b1, {name, "_rise"});
  endtask

  // Monitor: every commit edge (CLK_ falling without reset) pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK_);
      if (RESET || !mon_en) continue;
      #1;
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_commit: got PC %0h with empty scoreboard", PC);
      end else begin
        e = sb_q.pop_front();
        check(e.name, {10'd0, PC, m, l},
              {10'd0, e.pc, seg_ref(e.disp[7:4]), seg_ref(e.disp[3:0])});
      end
    end
  end

  initial begin
    RESET       = 1'b1;
    instruction = 8'd0;
    @(posedge _CLK);
    @(posedge _CLK);
    #1;
    RESET = 1'b0;
    check_reset_state("reset");
    check_rise_latency("reset");

    mon_en = 1'b1;
    for (int i = 0; i < 22; i++) begin
      issue(vecs[i].ins, $sformatf("vec%0d", i), vecs[i].pc, vecs[i].disp);
    end
    mon_en = 1'b0;
    check("scoreboard_drained", sb_q.size(), 0);

    // Reset coincident with a commit edge: reset must win.
    instruction = 8'b00000000;
    @(posedge _CLK);
    #1;
    RESET = 1'b1;
    @(posedge _CLK);
    #1;
    RESET = 1'b0;
    check_reset_state("coincident");
    check_rise_latency("coincident");

    // Memory restored by reset: M[1] back to 1 after the earlier store.
    mon_en = 1'b1;
    issue(8'b01000101, "lw_after_reset", 8'd1, 8'h01);
    mon_en = 1'b0;

    // Reset in the middle of the CLK_ high phase.
    RESET = 1'b1;
    @(posedge _CLK);
    #1;
    RESET = 1'b0;
    check_reset_state("midphase");
    check_rise_latency("midphase");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
